// File: rtl/project_pkg.sv
// Shared types and default geometry for the sensor capture controller.
package project_pkg;

   localparam int unsigned WIDTH_DEF  = 640;
   localparam int unsigned HEIGTH_DEF = 480;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned SKIP_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      SKIP    = 2'd2,
      CAPTURE = 2'd3
   } cap_state_t;

endpackage

// File: rtl/cap_geom_chk.sv
// Geometry checker: pixels per LV run and lines per frame against WIDTH/HEIGTH.
// Emits a one-cycle bad pulse on any mismatch while en is high.
module cap_geom_chk
   import project_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned HEIGTH = HEIGTH_DEF
)(
   input  logic pclk,
   input  logic resetn,
   input  logic en,
   input  logic lv,
   input  logic fv_fall,
   output logic bad
);

   localparam logic [15:0] PIX_EXP  = 16'(WIDTH);
   localparam logic [15:0] LINE_EXP = 16'(HEIGTH);

   logic        lv_q;
   logic        lv_fall;
   logic [15:0] pix_cnt;
   logic [15:0] line_cnt;
   logic [15:0] lines_done;

   assign lv_fall    = lv_q & ~lv;
   // a line closing on the same cycle as the frame still counts toward it
   assign lines_done = line_cnt + {15'd0, lv_fall};

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         lv_q     <= 1'b0;
         pix_cnt  <= '0;
         line_cnt <= '0;
         bad      <= 1'b0;
      end else begin
         lv_q <= lv;
         if (!en) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            bad      <= 1'b0;
         end else begin
            bad <= 1'b0;
            if (lv) pix_cnt <= pix_cnt + 16'd1;
            if (lv_fall) begin
               pix_cnt  <= '0;
               line_cnt <= line_cnt + 16'd1;
               if (pix_cnt != PIX_EXP) bad <= 1'b1;
            end
            if (fv_fall) begin
               pix_cnt  <= '0;
               line_cnt <= '0;
               if (lines_done != LINE_EXP) bad <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cap_ctrl.sv
// Capture controller gating sensor FV/LV into the capture core, with frame decimation.
// Optional geometry checking is enabled by defining CAP_CTRL_GEOM_EN.
module cap_ctrl
   import project_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned HEIGTH = HEIGTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned SKIP_W = SKIP_W_DEF
)(
   input  logic              pclk,
   input  logic              resetn,
   input  logic [DATA_W-1:0] D_IN,
   input  logic              FV_IN,
   input  logic              LV_IN,
   output logic [DATA_W-1:0] D_OUT,
   output logic              FV_OUT,
   output logic              LV_OUT,
   input  logic              start,
   input  logic              stop,
   input  logic              single,
   input  logic [SKIP_W-1:0] skip,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   output logic              err_geom
);

   cap_state_t        state;
   cap_state_t        nxt;
   logic [SKIP_W-1:0] skip_cnt;
   logic              stop_pend;
   logic              fv_q;
   logic              fv_rise;
   logic              fv_fall;
   logic              fwd;

   assign fv_rise = FV_IN & ~fv_q;
   assign fv_fall = ~FV_IN & fv_q;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start && !stop) nxt = ARMED;
         ARMED:   if (stop) nxt = IDLE;
                  else if (fv_rise) nxt = (skip_cnt == '0) ? CAPTURE : SKIP;
         SKIP:    if (stop) nxt = IDLE;
                  else if (fv_fall) nxt = ARMED;
         CAPTURE: if (fv_fall) nxt = (single || stop_pend || stop) ? IDLE : ARMED;
         default: nxt = IDLE;
      endcase
      // forwarding opens on the rising-edge cycle so the first FV beat is not lost
      fwd = (state == CAPTURE) || ((state == ARMED) && (nxt == CAPTURE));
   end

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         fv_q       <= 1'b0;
         D_OUT      <= '0;
         FV_OUT     <= 1'b0;
         LV_OUT     <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         skip_cnt   <= '0;
         stop_pend  <= 1'b0;
      end else begin
         state      <= nxt;
         busy       <= (nxt != IDLE);
         fv_q       <= FV_IN;
         D_OUT      <= D_IN;
         FV_OUT     <= FV_IN & fwd;
         LV_OUT     <= LV_IN & fwd;
         frame_done <= 1'b0;
         unique case (state)
            IDLE: if (nxt == ARMED) begin
               skip_cnt  <= skip;
               stop_pend <= 1'b0;
            end
            ARMED: if (nxt == SKIP) skip_cnt <= skip_cnt - 1'b1;
            CAPTURE: begin
               if (stop) stop_pend <= 1'b1;
               if (fv_fall) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
                  skip_cnt   <= skip;
                  stop_pend  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CAP_CTRL_GEOM_EN
   logic geom_bad;

   cap_geom_chk #(
      .WIDTH  (WIDTH),
      .HEIGTH (HEIGTH)
   ) u_geom (
      .pclk    (pclk),
      .resetn  (resetn),
      .en      (fwd),
      .lv      (LV_IN),
      .fv_fall (fv_fall),
      .bad     (geom_bad)
   );

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn)                          err_geom <= 1'b0;
      else if (state == IDLE && nxt == ARMED) err_geom <= 1'b0;
      else if (geom_bad)                    err_geom <= 1'b1;
   end
`else
   assign err_geom = 1'b0;
`endif

endmodule

// File: tb/tb_cap_ctrl.sv
// Self-checking bench for cap_ctrl: directed scenarios plus a randomized phase
// checked against a frame-level model of which frames are forwarded.
module tb_cap_ctrl;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int DW = 8;
   localparam int SW = 4;

   logic          pclk   = 1'b0;
   logic          resetn = 1'b0;
   logic [DW-1:0] D_IN   = '0;
   logic          FV_IN  = 1'b0;
   logic          LV_IN  = 1'b0;
   logic          start  = 1'b0;
   logic          stop   = 1'b0;
   logic          single = 1'b0;
   logic [SW-1:0] skip   = '0;
   logic [DW-1:0] D_OUT;
   logic          FV_OUT, LV_OUT, busy, frame_done, err_geom;
   logic [15:0]   frame_cnt;

   always #5 pclk = ~pclk;

   cap_ctrl #(.WIDTH(W), .HEIGTH(H), .DATA_W(DW), .SKIP_W(SW)) dut (
      .pclk       (pclk),
      .resetn     (resetn),
      .D_IN       (D_IN),
      .FV_IN      (FV_IN),
      .LV_IN      (LV_IN),
      .D_OUT      (D_OUT),
      .FV_OUT     (FV_OUT),
      .LV_OUT     (LV_OUT),
      .start      (start),
      .stop       (stop),
      .single     (single),
      .skip       (skip),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .err_geom   (err_geom)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // output monitor: running totals, sampled on the falling edge
   int            fv_rises = 0, lv_rises = 0, pix = 0, dones = 0, d_mis = 0;
   logic          fvo_q = 1'b0, lvo_q = 1'b0, dvalid = 1'b0;
   logic [DW-1:0] prev_din = '0;

   always @(negedge pclk) begin
      if (!resetn) begin
         dvalid = 1'b0;
         fvo_q  = 1'b0;
         lvo_q  = 1'b0;
      end else begin
         if (dvalid && D_OUT !== prev_din) d_mis++;
         prev_din = D_IN;
         dvalid   = 1'b1;
         if (FV_OUT && !fvo_q) fv_rises++;
         if (LV_OUT && !lvo_q) lv_rises++;
         if (LV_OUT) pix++;
         if (frame_done) dones++;
         fvo_q = FV_OUT;
         lvo_q = LV_OUT;
      end
   end

   // frame-level reference model
   bit          m_active = 0;
   int          m_skip_left = 0;
   bit          m_pend = 0;
   bit          m_err = 0;
   logic [15:0] m_cnt = '0;

   function automatic logic exp_err();
`ifdef CAP_CTRL_GEOM_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction

   task automatic cyc();
      @(posedge pclk);
      #1;
      if (!resetn) resetn = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_start();
      cyc(); start = 1'b1;
      cyc(); start = 1'b0;
      idle(2);
      if (!m_active) begin
         m_active = 1; m_skip_left = int'(skip); m_err = 0; m_pend = 0;
      end
      chk("start_busy", {31'd0, busy}, {31'd0, m_active});
      chk("start_err", {31'd0, err_geom}, {31'd0, exp_err()});
   endtask

   task automatic do_stop(input bit with_start);
      cyc(); stop = 1'b1; start = with_start;
      cyc(); stop = 1'b0; start = 1'b0;
      idle(2);
      m_active = 0;
      chk("stop_busy", {31'd0, busy}, 32'd0);
   endtask

   // kind: 0 none, 1 start, 2 stop, 3 reset -- applied at pixel 3 of hook_line
   task automatic send_frame(input int bad_line, input int hook_line, input int kind);
      int npix;
      cyc(); FV_IN = 1'b1; LV_IN = 1'b0; D_IN = DW'($urandom);
      cyc(); D_IN = DW'($urandom);
      for (int l = 0; l < H; l++) begin
         npix = (l == bad_line) ? W - 1 : W;
         for (int p = 0; p < npix; p++) begin
            cyc();
            LV_IN = 1'b1;
            D_IN  = DW'($urandom);
            start = (kind == 1 && l == hook_line && p == 3);
            stop  = (kind == 2 && l == hook_line && p == 3);
            if (kind == 3 && l == hook_line && p == 3) begin
               resetn = 1'b0;
               #1;
               chk("rst_fv_out", {31'd0, FV_OUT}, 32'd0);
               chk("rst_lv_out", {31'd0, LV_OUT}, 32'd0);
               chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
               chk("rst_busy", {31'd0, busy}, 32'd0);
            end
         end
         for (int g = 0; g < 2; g++) begin
            cyc(); LV_IN = 1'b0; start = 1'b0; stop = 1'b0; D_IN = DW'($urandom);
         end
      end
      cyc(); FV_IN = 1'b0; D_IN = DW'($urandom);
   endtask

   task automatic run_frame(input int bad_line, input int hook_line, input int kind);
      int b_fv, b_lv, b_pix, b_done, b_dm;
      bit fwd;
      b_fv = fv_rises; b_lv = lv_rises; b_pix = pix; b_done = dones; b_dm = d_mis;
      fwd = 0;
      if (m_active) begin
         if (m_skip_left == 0) fwd = 1;
         else m_skip_left--;
      end
      send_frame(bad_line, hook_line, kind);
      if (kind == 1 && !m_active) begin
         m_active = 1; m_skip_left = int'(skip); m_err = 0; m_pend = 0;
      end
      if (kind == 2) begin
         if (fwd) m_pend = 1;
         else m_active = 0;
      end
      if (kind == 3) begin
         m_active = 0; m_cnt = '0; m_err = 0; m_pend = 0; fwd = 0;
      end
      if (fwd) begin
         m_cnt = m_cnt + 16'd1;
         if (bad_line >= 0) m_err = 1;
         if (single || m_pend) begin
            m_active = 0; m_pend = 0;
         end else begin
            m_skip_left = int'(skip);
         end
      end
      idle(3 + $urandom_range(0, 2));
      chk("frame_done", dones - b_done, {31'd0, fwd});
      if (kind != 3) begin
         chk("fv_pulses", fv_rises - b_fv, {31'd0, fwd});
         chk("lv_pulses", lv_rises - b_lv, fwd ? H : 0);
         chk("pixels", pix - b_pix, fwd ? (H * W - ((bad_line >= 0) ? 1 : 0)) : 0);
         chk("d_out_pass", d_mis - b_dm, 32'd0);
      end
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("err_geom", {31'd0, err_geom}, {31'd0, exp_err()});
   endtask

   initial begin
      int r;
      resetn = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      chk("reset_fv_out", {31'd0, FV_OUT}, 32'd0);
      chk("reset_lv_out", {31'd0, LV_OUT}, 32'd0);
      chk("reset_d_out", {24'd0, D_OUT}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, frame_done}, 32'd0);
      chk("reset_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("reset_err", {31'd0, err_geom}, 32'd0);
      idle(3);

      // single shot: only the first of three frames passes
      single = 1'b1; skip = '0;
      do_start();
      repeat (3) run_frame(-1, -1, 0);

      // decimation by 3 over nine frames
      single = 1'b0; skip = SW'(2);
      do_start();
      repeat (9) run_frame(-1, -1, 0);
      do_stop(1'b0);

      // start mid-frame: that frame is blocked, the next is whole
      single = 1'b1; skip = '0;
      run_frame(-1, 1, 1);
      run_frame(-1, -1, 0);

      // stop inside a captured frame lets it finish, then blocks
      single = 1'b0; skip = '0;
      do_start();
      run_frame(-1, 0, 2);
      run_frame(-1, -1, 0);

      // short line, error sticks until the next accepted start
      single = 1'b1;
      do_start();
      run_frame(1, -1, 0);
      run_frame(-1, -1, 0);
      do_start();
      run_frame(-1, -1, 0);

      // start and stop together resolve as stop
      do_stop(1'b1);
      run_frame(-1, -1, 0);

      // randomized commands and frames
      for (int i = 0; i < 16; i++) begin
         r = $urandom_range(0, 5);
         if (r == 0) begin
            skip   = SW'($urandom_range(0, 2));
            single = 1'($urandom_range(0, 1));
            do_start();
         end else if (r == 1) begin
            do_stop(1'b0);
         end else begin
            run_frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, H - 1)) : -1, -1, 0);
         end
      end

      // reset in the middle of a forwarded line
      single = 1'b0; skip = '0;
      do_start();
      run_frame(-1, 1, 3);
      single = 1'b1;
      do_start();
      run_frame(-1, -1, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cap_ctrl.md
CAP_CTRL -- requirements
Module: cap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter HEIGTH, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter DATA_W, default 8, meaning pixel data width.
REQ-004 SHALL have parameter SKIP_W, default 4, meaning width of the frame-decimation field.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named pclk and resetn.
REQ-006 SHALL have ports:
- pclk  in  1  pixel clock.
- resetn  in  1  async active-low reset.
- D_IN  in  DATA_W  sensor pixel data.
- FV_IN, LV_IN  in  1 each  sensor frame/line valid.
- D_OUT  out  DATA_W  registered data to capture core.
- FV_OUT, LV_OUT  out  1 each  gated frame/line valid to capture core.
- start  in  1  single-cycle arm command.
- stop  in  1  single-cycle stop command.
- single  in  1  1 = capture one frame and then idle; 0 = continuous.
- skip  in  SKIP_W  forward 1 of every skip+1 frames.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse per forwarded frame.
- frame_cnt  out  16  count of forwarded frames.
- err_geom  out  1  sticky geometry error.

Function
REQ-007 SHALL register D_IN, FV_IN and LV_IN once, giving D_OUT, FV_OUT and LV_OUT a latency of exactly 1 cycle. D_OUT SHALL always pass data; FV_OUT and LV_OUT SHALL be forced to 0 outside forwarding.
REQ-008 SHALL implement the FSM states IDLE, ARMED, SKIP and CAPTURE, held in a cap_state_t register.
REQ-009 IDLE: on start, SHALL load skip_cnt from skip, clear stop_pend and err_geom, and go to ARMED.
REQ-010 ARMED: on an FV_IN rising edge (FV_IN=1, previous FV_IN=0), SHALL go to CAPTURE if skip_cnt==0; otherwise it SHALL decrement skip_cnt and go to SKIP.
REQ-011 ARMED SHALL never enter CAPTURE mid-frame, so partial frames are never forwarded.
REQ-012 SKIP: on an FV_IN falling edge, SHALL return to ARMED.
REQ-013 CAPTURE: FV_OUT/LV_OUT SHALL follow the inputs, starting with the cycle after the rising edge is registered, so the whole frame passes.
REQ-014 CAPTURE: on an FV_IN falling edge, SHALL pulse frame_done and increment frame_cnt. The next state SHALL be IDLE if single or stop_pend is set; otherwise it SHALL reload skip_cnt from skip and go to ARMED.
REQ-015 stop SHALL move ARMED or SKIP to IDLE on the next cycle; in CAPTURE it SHALL set stop_pend so that the current frame completes.
REQ-016 start outside IDLE SHALL be ignored; start and stop in the same cycle SHALL resolve as stop.
REQ-017 frame_cnt SHALL wrap from 16'hFFFF to 0 and SHALL be cleared only by reset.
REQ-018 An FV_IN falling edge and a rising edge cannot occur in the same cycle; a rising edge in the cycle after a capture completes SHALL be honoured from ARMED.

Reset
REQ-019 Asserting resetn=0 SHALL immediately force: state=IDLE; FV_OUT, LV_OUT, busy, frame_done and err_geom =0; D_OUT, frame_cnt, skip_cnt and edge registers =0; stop_pend=0.
REQ-020 Reset asserted mid-frame SHALL drop FV_OUT and LV_OUT immediately (truncated frame, downstream resynchronises on its next FV).

Configuration
REQ-021 With CAP_CTRL_GEOM_EN defined: during CAPTURE the block SHALL count pixels per LV_IN-high run and compare the count to WIDTH at LV_IN fall, and count lines and compare to HEIGTH at FV_IN fall. Any mismatch SHALL set err_geom (sticky, cleared by reset or an accepted start).
REQ-022 Without CAP_CTRL_GEOM_EN: err_geom SHALL be tied to 0 and the counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-023 cap_state_t and the default-parameter constants SHALL live in project_pkg.
REQ-024 The geometry checker SHALL be a sub-module, cap_geom_chk, instantiated only under CAP_CTRL_GEOM_EN.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (WIDTH=8, HEIGTH=4, pclk 10 ns):
- Single shot: single=1, skip=0, start, 3 frames sent -> exactly 1 frame forwarded, frame_done x1, frame_cnt=1, busy=0 afterwards.
- Decimation: single=0, skip=2, 9 frames -> frames 3, 6 and 9 forwarded, frame_cnt=3.
- Mid-frame start: start during line 2 of a frame -> that frame is blocked and the next full frame is forwarded with 4 LV pulses of 8 pixels.
- Stop in CAPTURE: stop during line 1 -> current frame completes (4 lines), then IDLE; the next frame is blocked.
- Geometry (macro on): a line of 7 pixels -> err_geom=1 after LV fall, held until the next start; with the macro off -> err_geom=0.
- Reset mid-frame: resetn low during a line -> FV_OUT=LV_OUT=0 the same cycle, frame_cnt=0, state IDLE.
